// File: rtl/motion_arbiter.sv
// -----------------------------------------------------------------------------
// motion_arbiter
//
// Sets the pace of the block/ship sprite's position. The system clock is
// divided into move ticks. On each tick the four direction requests are
// arbitrated round-robin, and the winner moves the sprite one step, wrapping at
// the screen edges. If the same direction is granted for ACCEL_TICKS ticks in a
// row, the step grows from STEP to STEP_FAST. A recenter request beats every
// direction. A freeze request halts both the tick divider and all motion.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low (asserted when 0)
//   up         level request, move toward Y_MIN
//   down       level request, move toward Y_MAX
//   left       level request, move toward X_MIN
//   right      level request, move toward X_MAX
//   recenter   level; on a tick, return to (X_CTR, Y_CTR)
//   freeze     level; holds the tick counter and suppresses ticks
//   xpos       sprite centre x (hCount domain)
//   ypos       sprite centre y (vCount domain)
//   dir        last granted direction: 0 right, 1 left, 2 up, 3 down
//   moving     1 while the most recent tick granted a direction
//   move_pulse one-cycle pulse in the cycle after any position change
//   fast       1 while STEP_FAST is in effect
//
// All outputs come straight from registers. There is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module motion_arbiter #(
  parameter int TICK_DIV    = 500000,
  parameter int STEP        = 2,
  parameter int STEP_FAST   = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int X_MIN       = 150,
  parameter int X_MAX       = 780,
  parameter int Y_MIN       = 35,
  parameter int Y_MAX       = 514,
  parameter int X_CTR       = 450,
  parameter int Y_CTR       = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       recenter,
  input  logic       freeze,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [1:0] dir,
  output logic       moving,
  output logic       move_pulse,
  output logic       fast
);

  // ---------------------------------------------------------------------------
  // Widths and sized constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RUN_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(ACCEL_TICKS);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  // Position arithmetic is done 11 bits wide, so xpos+step never overflows
  // before it is compared against the wrap bound.
  localparam logic [10:0] STEP_W      = 11'(STEP);
  localparam logic [10:0] STEP_FAST_W = 11'(STEP_FAST);
  localparam logic [10:0] X_MIN_W     = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W     = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W     = 11'(Y_MAX);
  localparam logic [9:0]  X_MIN_P     = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_P     = 10'(X_MAX);
  localparam logic [9:0]  Y_MIN_P     = 10'(Y_MIN);
  localparam logic [9:0]  Y_MAX_P     = 10'(Y_MAX);
  localparam logic [9:0]  X_CTR_P     = 10'(X_CTR);
  localparam logic [9:0]  Y_CTR_P     = 10'(Y_CTR);

  // Direction encoding, shared by dir, rr_ptr and the request vector index.
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] tick_cnt_reg,   tick_cnt_next;
  logic [1:0]       rr_ptr_reg,     rr_ptr_next;
  logic [RUN_W-1:0] run_cnt_reg,    run_cnt_next;
  logic [9:0]       xpos_reg,       xpos_next;
  logic [9:0]       ypos_reg,       ypos_next;
  logic [1:0]       dir_reg,        dir_next;
  logic             moving_reg,     moving_next;
  logic             move_pulse_reg, move_pulse_next;
  logic             fast_reg,       fast_next;

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  logic tick;

  assign tick = (tick_cnt_reg == TICK_LAST) && !freeze;

  always_comb begin
    tick_cnt_next = tick_cnt_reg;
    if (!freeze) begin
      if (tick_cnt_reg == TICK_LAST) begin
        tick_cnt_next = '0;
      end else begin
        tick_cnt_next = tick_cnt_reg + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // Slot gi of the rotated view holds the request at position rr_ptr+gi (mod 4).
  // The lowest active slot wins, so the search starts at rr_ptr.
  // ---------------------------------------------------------------------------
  logic [3:0] req;
  logic [1:0] cand_idx [4];
  logic [3:0] cand_req;
  logic       grant_valid;
  logic [1:0] grant_idx;

  assign req = {down, up, left, right};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rotate
      assign cand_idx[gi] = rr_ptr_reg + 2'(gi);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step size and wrapped candidate positions
  // The step is chosen from the run length accumulated before this tick, so
  // the (ACCEL_TICKS+1)-th consecutive grant is the first fast one.
  // ---------------------------------------------------------------------------
  logic        use_fast;
  logic [10:0] step_sel;
  logic [10:0] x_ext, y_ext;
  logic [10:0] x_plus, x_minus, y_plus, y_minus;
  logic [9:0]  x_right_pos, x_left_pos, y_down_pos, y_up_pos;

  assign use_fast = (run_cnt_reg >= RUN_MAX);
  assign step_sel = use_fast ? STEP_FAST_W : STEP_W;
  assign x_ext    = {1'b0, xpos_reg};
  assign y_ext    = {1'b0, ypos_reg};
  assign x_plus   = x_ext + step_sel;
  assign x_minus  = x_ext - step_sel;
  assign y_plus   = y_ext + step_sel;
  assign y_minus  = y_ext - step_sel;

  // Moving past either bound jumps to the opposite bound. The subtraction is
  // guarded by the comparison, so x_minus/y_minus never underflow when used.
  assign x_right_pos = (x_plus > X_MAX_W)             ? X_MIN_P : x_plus[9:0];
  assign x_left_pos  = (x_ext < (X_MIN_W + step_sel)) ? X_MAX_P : x_minus[9:0];
  assign y_down_pos  = (y_plus > Y_MAX_W)             ? Y_MIN_P : y_plus[9:0];
  assign y_up_pos    = (y_ext < (Y_MIN_W + step_sel)) ? Y_MAX_P : y_minus[9:0];

  // ---------------------------------------------------------------------------
  // Per-tick update
  // moving_reg/dir_reg record what the previous tick granted. Together they
  // show whether this grant continues an unbroken run.
  // ---------------------------------------------------------------------------
  logic same_run;

  assign same_run = moving_reg && (grant_idx == dir_reg);

  always_comb begin
    rr_ptr_next     = rr_ptr_reg;
    run_cnt_next    = run_cnt_reg;
    xpos_next       = xpos_reg;
    ypos_next       = ypos_reg;
    dir_next        = dir_reg;
    moving_next     = moving_reg;
    fast_next       = fast_reg;
    move_pulse_next = 1'b0;

    if (tick) begin
      if (recenter) begin
        xpos_next       = X_CTR_P;
        ypos_next       = Y_CTR_P;
        moving_next     = 1'b0;
        run_cnt_next    = '0;
        fast_next       = 1'b0;
        move_pulse_next = (xpos_reg != X_CTR_P) || (ypos_reg != Y_CTR_P);
      end else if (grant_valid) begin
        dir_next        = grant_idx;
        moving_next     = 1'b1;
        move_pulse_next = 1'b1;
        fast_next       = use_fast;
        rr_ptr_next     = grant_idx + 2'd1;
        if (same_run) begin
          run_cnt_next = (run_cnt_reg >= RUN_MAX) ? RUN_MAX : run_cnt_reg + RUN_ONE;
        end else begin
          run_cnt_next = RUN_ONE;
        end
        unique case (grant_idx)
          DIR_RIGHT: xpos_next = x_right_pos;
          DIR_LEFT:  xpos_next = x_left_pos;
          DIR_UP:    ypos_next = y_up_pos;
          DIR_DOWN:  ypos_next = y_down_pos;
          default:   xpos_next = xpos_reg;
        endcase
      end else begin
        moving_next  = 1'b0;
        run_cnt_next = '0;
        fast_next    = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_reg   <= '0;
      rr_ptr_reg     <= DIR_RIGHT;
      run_cnt_reg    <= '0;
      xpos_reg       <= X_CTR_P;
      ypos_reg       <= Y_CTR_P;
      dir_reg        <= DIR_RIGHT;
      moving_reg     <= 1'b0;
      move_pulse_reg <= 1'b0;
      fast_reg       <= 1'b0;
    end else begin
      tick_cnt_reg   <= tick_cnt_next;
      rr_ptr_reg     <= rr_ptr_next;
      run_cnt_reg    <= run_cnt_next;
      xpos_reg       <= xpos_next;
      ypos_reg       <= ypos_next;
      dir_reg        <= dir_next;
      moving_reg     <= moving_next;
      move_pulse_reg <= move_pulse_next;
      fast_reg       <= fast_next;
    end
  end

  assign xpos       = xpos_reg;
  assign ypos       = ypos_reg;
  assign dir        = dir_reg;
  assign moving     = moving_reg;
  assign move_pulse = move_pulse_reg;
  assign fast       = fast_reg;

endmodule

// File: tb/tb_motion_arbiter.sv
// -----------------------------------------------------------------------------
// tb_motion_arbiter
//
// Directed bench for motion_arbiter with TICK_DIV=4. Every scenario starts from
// a reset that is released on a falling edge. The fourth rising edge after that
// is then a tick edge, and so is every fourth edge after it. Inputs change on
// falling edges. Outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_motion_arbiter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       recenter = 1'b0, freeze = 1'b0;
  logic [9:0] xpos, ypos;
  logic [1:0] dir;
  logic       moving, move_pulse, fast;

  int n_cmp = 0;
  int n_bad = 0;

  motion_arbiter #(
    .TICK_DIV(TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .recenter  (recenter),
    .freeze    (freeze),
    .xpos      (xpos),
    .ypos      (ypos),
    .dir       (dir),
    .moving    (moving),
    .move_pulse(move_pulse),
    .fast      (fast)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside)
  task automatic set_dirs(input logic r, input logic l, input logic u, input logic d);
    right = r; left = l; up = u; down = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_dirs(0, 0, 0, 0);
    recenter = 1'b0;
    freeze   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance n ticks. The caller must be sitting on a tick-aligned falling edge.
  task automatic ticks(input int n);
    repeat (n * TD) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (xpos !== 10'd450 || ypos !== 10'd250 || dir !== 2'd0 || moving !== 1'b0 ||
        move_pulse !== 1'b0 || fast !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got x=%0d y=%0d dir=%0d mv=%b mp=%b f=%b, want 450 250 0 0 0 0",
               xpos, ypos, dir, moving, move_pulse, fast);
    end
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (move_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_pulse cycle %0d: got %b want 0", c, move_pulse);
      end
    end
    n_cmp++;
    if (xpos !== 10'd450 || ypos !== 10'd250 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_pos: got x=%0d y=%0d mv=%b want 450 250 0", xpos, ypos, moving);
    end
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_accel();
    int exp_x;
    do_reset();
    set_dirs(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      ticks(1);
      exp_x = (k <= 8) ? 450 + 2 * k : 466 + 4 * (k - 8);
      n_cmp++;
      if (xpos !== 10'(exp_x) || dir !== 2'd0 || moving !== 1'b1 ||
          move_pulse !== 1'b1 || fast !== (k >= 9)) begin
        n_bad++;
        $display("FAIL accel tick %0d: got x=%0d dir=%0d mv=%b mp=%b f=%b, want x=%0d dir=0 mv=1 mp=1 f=%b",
                 k, xpos, dir, moving, move_pulse, fast, exp_x, (k >= 9));
      end
    end
    set_dirs(0, 0, 0, 0);
    ticks(1);
    n_cmp++;
    if (xpos !== 10'd474 || moving !== 1'b0 || fast !== 1'b0 || move_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL accel_release: got x=%0d mv=%b f=%b mp=%b want 474 0 0 0",
               xpos, moving, fast, move_pulse);
    end
    $display("test_accel done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_opposing();
    logic [9:0] exp_x;
    logic [1:0] exp_d;
    do_reset();
    set_dirs(1, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      ticks(1);
      exp_x = (k % 2 == 1) ? 10'd452 : 10'd450;
      exp_d = (k % 2 == 1) ? 2'd0 : 2'd1;
      n_cmp++;
      if (xpos !== exp_x || dir !== exp_d || fast !== 1'b0 || moving !== 1'b1) begin
        n_bad++;
        $display("FAIL opposing tick %0d: got x=%0d dir=%0d f=%b mv=%b want x=%0d dir=%0d f=0 mv=1",
                 k, xpos, dir, fast, moving, exp_x, exp_d);
      end
    end
    $display("test_opposing done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    do_reset();
    set_dirs(1, 0, 0, 0); ticks(1);   // 452
    set_dirs(0, 0, 0, 0); ticks(1);   // idle, run restarts
    set_dirs(1, 0, 0, 0); ticks(86);  // 8 x 2 + 78 x 4 -> 780
    n_cmp++;
    if (xpos !== 10'd780) begin
      n_bad++;
      $display("FAIL wrap_preload_x: got %0d want 780", xpos);
    end
    ticks(1);
    n_cmp++;
    if (xpos !== 10'd150 || ypos !== 10'd250 || dir !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_right: got x=%0d y=%0d dir=%0d want 150 250 0", xpos, ypos, dir);
    end
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(0, 0, 1, 0); ticks(1);   // 248
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(0, 0, 1, 0); ticks(57);  // 8 x 2 + 49 x 4 -> 36
    n_cmp++;
    if (ypos !== 10'd36) begin
      n_bad++;
      $display("FAIL wrap_preload_y: got %0d want 36", ypos);
    end
    ticks(1);
    n_cmp++;
    if (ypos !== 10'd514 || xpos !== 10'd150 || dir !== 2'd2) begin
      n_bad++;
      $display("FAIL wrap_up: got y=%0d x=%0d dir=%0d want 514 150 2", ypos, xpos, dir);
    end
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(0, 0, 0, 1); ticks(1);
    n_cmp++;
    if (ypos !== 10'd35 || dir !== 2'd3 || fast !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_down: got y=%0d dir=%0d f=%b want 35 3 0", ypos, dir, fast);
    end
    $display("test_wrap done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_freeze();
    do_reset();
    set_dirs(0, 0, 0, 1);
    ticks(1);                          // 252, tick_cnt now 0
    repeat (2) @(posedge clk);
    @(negedge clk);                    // tick_cnt now 2
    freeze = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ypos !== 10'd252 || move_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL freeze cycle %0d: got y=%0d mp=%b want 252 0", c, ypos, move_pulse);
      end
    end
    freeze = 1'b0;
    @(negedge clk);                    // tick_cnt 2 -> 3, no tick yet
    n_cmp++;
    if (ypos !== 10'd252) begin
      n_bad++;
      $display("FAIL unfreeze_early: got y=%0d want 252", ypos);
    end
    @(negedge clk);                    // tick lands here
    n_cmp++;
    if (ypos !== 10'd254 || move_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL unfreeze_tick: got y=%0d mp=%b want 254 1", ypos, move_pulse);
    end
    $display("test_freeze done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_recenter_reset();
    do_reset();
    set_dirs(1, 0, 0, 0); ticks(1);   // 452
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(1, 0, 0, 0); ticks(16);  // 8 x 2 + 8 x 4 -> 500
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(0, 0, 1, 0); ticks(1);   // 248
    set_dirs(0, 0, 0, 0); ticks(1);
    set_dirs(0, 0, 1, 0); ticks(41);  // 8 x 2 + 33 x 4 -> 100
    n_cmp++;
    if (xpos !== 10'd500 || ypos !== 10'd100 || fast !== 1'b1) begin
      n_bad++;
      $display("FAIL recenter_preload: got x=%0d y=%0d f=%b want 500 100 1", xpos, ypos, fast);
    end
    recenter = 1'b1;                   // up still held
    ticks(1);
    n_cmp++;
    if (xpos !== 10'd450 || ypos !== 10'd250 || moving !== 1'b0 || move_pulse !== 1'b1 ||
        dir !== 2'd2 || fast !== 1'b0) begin
      n_bad++;
      $display("FAIL recenter: got x=%0d y=%0d mv=%b mp=%b dir=%0d f=%b want 450 250 0 1 2 0",
               xpos, ypos, moving, move_pulse, dir, fast);
    end
    recenter = 1'b0;
    set_dirs(1, 0, 0, 0);
    @(negedge clk);                    // tick_cnt now 1
    n_cmp++;
    if (move_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_width: got %b want 0", move_pulse);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (xpos !== 10'd452 || dir !== 2'd0) begin
      n_bad++;
      $display("FAIL pre_reset_move: got x=%0d dir=%0d want 452 0", xpos, dir);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (xpos !== 10'd450 || ypos !== 10'd250 || dir !== 2'd0 || moving !== 1'b0 ||
        move_pulse !== 1'b0 || fast !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got x=%0d y=%0d dir=%0d mv=%b mp=%b f=%b want 450 250 0 0 0 0",
               xpos, ypos, dir, moving, move_pulse, fast);
    end
    @(negedge clk);
    rst = 1'b1;                        // right still held
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (xpos !== 10'd450) begin
      n_bad++;
      $display("FAIL phase_restart_early: got x=%0d want 450", xpos);
    end
    @(negedge clk);
    n_cmp++;
    if (xpos !== 10'd452 || move_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL phase_restart_tick: got x=%0d mp=%b want 452 1", xpos, move_pulse);
    end
    $display("test_recenter_reset done");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_accel();
    test_opposing();
    test_wrap();
    test_freeze();
    test_recenter_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/motion_arbiter.md
Name: motion_arbiter

Overview:
Paced position controller for the on-screen block/ship sprite. It divides the system clock into move ticks and round-robin arbitrates the four direction requesters on each tick. It applies one step per tick with edge wrap-around, accelerates on a sustained press, and outputs the sprite centre (xpos, ypos) plus the granted direction to the renderer and background logic.

Parameters:
TICK_DIV, 500000, clk cycles per move tick (>=2)
STEP, 2, pixels per tick, normal speed
STEP_FAST, 4, pixels per tick after acceleration
ACCEL_TICKS, 8, consecutive same-direction grants before STEP_FAST applies
X_MIN, 150, left wrap bound (hCount domain)
X_MAX, 780, right wrap bound
Y_MIN, 35, top wrap bound (vCount domain)
Y_MAX, 514, bottom wrap bound
X_CTR, 450, reset/recenter x
Y_CTR, 250, reset/recenter y

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
up  in  1  level request, move toward Y_MIN
down  in  1  level request, move toward Y_MAX
left  in  1  level request, move toward X_MIN
right  in  1  level request, move toward X_MAX
recenter  in  1  level; on a tick, return to centre (beats all directions)
freeze  in  1  level; halts the tick counter and all motion
xpos  out  10  sprite centre x
ypos  out  10  sprite centre y
dir  out  2  last granted direction: 0 right, 1 left, 2 up, 3 down
moving  out  1  1 while a direction was granted on the most recent tick
move_pulse  out  1  one-cycle pulse in the cycle after any position change
fast  out  1  1 while STEP_FAST is in effect

Behaviour:
- Reset (rst=0, async): xpos=X_CTR, ypos=Y_CTR, dir=0, moving=0, move_pulse=0, fast=0, tick_cnt=0, rr_ptr=0 (right), run_cnt=0.
- Tick counter: tick_cnt counts 0..TICK_DIV-1 and wraps. Tick cycle = the cycle with tick_cnt==TICK_DIV-1 and freeze=0. freeze=1 holds tick_cnt and suppresses ticks. Outputs hold, and move_pulse is 0 on the following cycle.
- Requests are sampled only in the tick cycle. All state updates at that cycle's clock edge, so new xpos/ypos are visible on the next cycle. move_pulse is high for exactly that one next cycle.
- Priority at a tick: recenter > arbitrated direction > idle.
- Recenter: xpos=X_CTR, ypos=Y_CTR; moving=0; run_cnt=0; fast=0; dir unchanged. move_pulse fires only if the position changed.
- Arbitration: round-robin over order right(0), left(1), up(2), down(3). Search starts at rr_ptr. The first active request wins. After a grant, rr_ptr = granted+1 mod 4. No request: moving=0, run_cnt=0, fast=0, rr_ptr unchanged.
- Opposing simultaneous requests (left+right, or up+down) are not cancelled. They alternate tick-by-tick under round-robin.
- Acceleration: if the grant equals the previous tick's grant (and the previous tick granted), run_cnt = min(run_cnt+1, ACCEL_TICKS); otherwise run_cnt=1. The step used this tick is STEP_FAST if run_cnt (before update) >= ACCEL_TICKS, else STEP. fast reflects the step used.
- Step and wrap, with step s (arithmetic is 11-bit internally, no 10-bit overflow):
  - right: if xpos+s > X_MAX then xpos=X_MIN, else xpos+s.
  - left: if xpos < X_MIN+s then xpos=X_MAX, else xpos-s.
  - down: if ypos+s > Y_MAX then ypos=Y_MIN, else ypos+s.
  - up: if ypos < Y_MIN+s then ypos=Y_MAX, else ypos-s.
  - The non-moving axis is unchanged.
- Grant outputs: dir=granted, moving=1, move_pulse fires on the next cycle.
- Reset mid-run clears everything immediately. The tick phase restarts from 0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. TICK_DIV=4, defaults; reset release, no input for 12 cycles -> xpos=450, ypos=250, moving=0, move_pulse never high.
2. right held -> xpos 452, 454, 456... on successive ticks; dir=0; the 9th grant onward steps by 4 with fast=1; release -> fast=0 and moving=0 at the next tick.
3. left+right both held from rr_ptr=0 -> grants alternate R, L, R, L; xpos oscillates 450/452 (stays at STEP); run_cnt never exceeds 1.
4. Wrap: preload via right until xpos=780; next right tick -> 150. From ypos=36, an up tick -> 514. From 514, a down tick -> 35.
5. freeze=1 for 20 cycles with down held -> ypos and tick_cnt frozen; on freeze=0 the next tick lands after the remaining count.
6. recenter+up on the same tick at (500,100) -> (450,250), moving=0, move_pulse=1 next cycle; assert rst=0 mid-tick -> immediate reset values.
